led_chaser: RTL and testbench

//  Generalised successor of the two-LED up/down blinker. One lit position runs

---
 rtl/led_chaser.sv | 147 ++++++++++++++
 tb/tb_led_chaser.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/led_chaser.sv
// led_chaser: a single lit position sweeps across N_LEDS outputs in one of
// three modes (UP, DOWN, BOUNCE). A rising edge on the debounced button moves
// to the next mode in the cycle UP -> DOWN -> BOUNCE -> UP. An internal tick
// divider sets the step rate, so the block runs directly from the system clock.
//
// Optional feature macro: LED_CHASER_TRAIL_EN
//   defined   - the previous position is also lit, giving a two-LED trail.
//   undefined - only the current position is lit.
//
// The mode register is the FSM state and is visible on the mode output.
// Every output is registered, so btn has no combinational path to any output.
module led_chaser #(
   parameter int N_LEDS   = 8,
   parameter int TICK_DIV = 50_000_000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              btn,
   output logic [N_LEDS-1:0] led,
   output logic [1:0]        mode,
   output logic              dir,
   output logic              step
);

   localparam int PW = $clog2(N_LEDS);
   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   localparam logic [PW-1:0] POS_LAST = PW'(N_LEDS - 1);
   localparam logic [PW-1:0] POS_PEN  = PW'(N_LEDS - 2);
   localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

   localparam logic [1:0] MODE_UP     = 2'd0;
   localparam logic [1:0] MODE_DOWN   = 2'd1;
   localparam logic [1:0] MODE_BOUNCE = 2'd2;

   logic          btn_q;
   logic [CW-1:0] cnt;
   logic [PW-1:0] pos;

   logic          btn_rise;
   logic          tick;
   logic [CW-1:0] cnt_nxt;
   logic [PW-1:0] pos_nxt;
   logic [1:0]    mode_nxt;
   logic          dir_nxt;
   logic [N_LEDS-1:0] led_nxt;

`ifdef LED_CHASER_TRAIL_EN
   logic [PW-1:0] prev_pos;
   logic [PW-1:0] prev_pos_nxt;
`endif

   // State register: reset overrides everything; btn_q still tracks btn during
   // reset so a button held through reset produces no edge on release.
   always_ff @(posedge clk) begin
      if (rst) begin
         btn_q <= btn;
         cnt   <= '0;
         pos   <= '0;
         mode  <= MODE_UP;
         dir   <= 1'b1;
         step  <= 1'b0;
         led   <= N_LEDS'(1);
`ifdef LED_CHASER_TRAIL_EN
         prev_pos <= '0;
`endif
      end else begin
         btn_q <= btn;
         cnt   <= cnt_nxt;
         pos   <= pos_nxt;
         mode  <= mode_nxt;
         dir   <= dir_nxt;
         step  <= tick;
         led   <= led_nxt;
`ifdef LED_CHASER_TRAIL_EN
         prev_pos <= prev_pos_nxt;
`endif
      end
   end

   // Next-state logic: the step uses the mode/dir held before this edge, then a
   // button edge overrides mode and (for UP/DOWN entry) dir on the same edge.
   always_comb begin
      btn_rise = btn & ~btn_q;
      tick     = (cnt == CNT_LAST);
      cnt_nxt  = tick ? '0 : cnt + 1'b1;
      pos_nxt  = pos;
      dir_nxt  = dir;
      mode_nxt = mode;

      if (tick) begin
         case (mode)
            MODE_DOWN: begin
               pos_nxt = (pos == '0) ? POS_LAST : pos - 1'b1;
            end
            MODE_BOUNCE: begin
               if (dir && (pos == POS_LAST)) begin
                  pos_nxt = POS_PEN;
                  dir_nxt = 1'b0;
               end else if (!dir && (pos == '0)) begin
                  pos_nxt = PW'(1);
                  dir_nxt = 1'b1;
               end else if (dir) begin
                  pos_nxt = pos + 1'b1;
               end else begin
                  pos_nxt = pos - 1'b1;
               end
            end
            // UP, and the unreachable encoding 3, both step upward.
            default: begin
               pos_nxt = (pos == POS_LAST) ? '0 : pos + 1'b1;
            end
         endcase
      end

      if (btn_rise) begin
         case (mode)
            MODE_UP: begin
               mode_nxt = MODE_DOWN;
               dir_nxt  = 1'b0;
            end
            MODE_DOWN: begin
               mode_nxt = MODE_BOUNCE;
            end
            default: begin
               mode_nxt = MODE_UP;
               dir_nxt  = 1'b1;
            end
         endcase
      end
   end

   // Output logic: LED pattern for the position being loaded this edge.
   always_comb begin
`ifdef LED_CHASER_TRAIL_EN
      prev_pos_nxt = tick ? pos : prev_pos;
      for (int i = 0; i < N_LEDS; i++) begin
         led_nxt[i] = (pos_nxt == PW'(i)) || (prev_pos_nxt == PW'(i));
      end
`else
      for (int i = 0; i < N_LEDS; i++) begin
         led_nxt[i] = (pos_nxt == PW'(i));
      end
`endif
   end

endmodule

// File: tb/tb_led_chaser.sv
// Bench for led_chaser. Two instances share clk/rst/btn: a 4-LED chaser with a
// 3-cycle tick and a 2-LED chaser stepping every cycle. A behavioural model
// predicts each instance's outputs per cycle and queues them; a monitor pops
// and compares after every rising edge.
module tb_led_chaser;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       btn = 1'b0;
   logic [3:0] led0;
   logic [1:0] mode0;
   logic       dir0;
   logic       step0;
   logic [1:0] led1;
   logic [1:0] mode1;
   logic       dir1;
   logic       step1;

   int checks = 0;
   int fails  = 0;

   logic [7:0] exp_q0[$];
   logic [7:0] exp_q1[$];

   // model state, index 0 = 4 LEDs / tick 3, index 1 = 2 LEDs / tick 1
   int n_leds[2] = '{4, 2};
   int tdiv[2]   = '{3, 1};
   int m_pos[2];
   int m_prev[2];
   int m_dir[2];
   int m_mode[2];
   int m_cnt[2];
   int m_btnq[2];
   int m_step[2];
   int cyc = 0;

   // clock / DUTs
   always #5 clk = ~clk;

   led_chaser #(.N_LEDS(4), .TICK_DIV(3)) dut0 (
      .clk(clk), .rst(rst), .btn(btn),
      .led(led0), .mode(mode0), .dir(dir0), .step(step0)
   );

   led_chaser #(.N_LEDS(2), .TICK_DIV(1)) dut1 (
      .clk(clk), .rst(rst), .btn(btn),
      .led(led1), .mode(mode1), .dir(dir1), .step(step1)
   );

   // Reference model: one clock edge of instance k given rst/btn.
   task automatic model_cycle(input int k, input bit r, input bit b);
      int rise;
      if (r) begin
         m_pos[k] = 0; m_prev[k] = 0; m_dir[k] = 1; m_mode[k] = 0;
         m_cnt[k] = 0; m_step[k] = 0; m_btnq[k] = b;
         return;
      end
      rise = (b && !m_btnq[k]) ? 1 : 0;
      m_btnq[k] = b;
      m_step[k] = (m_cnt[k] == tdiv[k] - 1) ? 1 : 0;
      m_cnt[k]  = m_step[k] ? 0 : m_cnt[k] + 1;
      if (m_step[k]) begin
         m_prev[k] = m_pos[k];
         if (m_mode[k] == 1) begin
            m_pos[k] = (m_pos[k] + n_leds[k] - 1) % n_leds[k];
         end else if (m_mode[k] == 2) begin
            if (m_dir[k] == 1 && m_pos[k] == n_leds[k] - 1) begin
               m_pos[k] = n_leds[k] - 2; m_dir[k] = 0;
            end else if (m_dir[k] == 0 && m_pos[k] == 0) begin
               m_pos[k] = 1; m_dir[k] = 1;
            end else begin
               m_pos[k] = m_pos[k] + (m_dir[k] ? 1 : -1);
            end
         end else begin
            m_pos[k] = (m_pos[k] + 1) % n_leds[k];
         end
      end
      if (rise) begin
         m_mode[k] = (m_mode[k] >= 2) ? 0 : m_mode[k] + 1;
         if (m_mode[k] == 0) m_dir[k] = 1;
         if (m_mode[k] == 1) m_dir[k] = 0;
      end
   endtask

   function automatic logic [7:0] model_out(input int k);
      logic [3:0] lv;
      lv = 4'(1 << m_pos[k]);
`ifdef LED_CHASER_TRAIL_EN
      lv = lv | 4'(1 << m_prev[k]);
`endif
      return {lv, 2'(m_mode[k]), 1'(m_dir[k]), 1'(m_step[k])};
   endfunction

   // Driver: apply inputs away from the active edge, push expected outputs.
   task automatic drive(input bit r, input bit b);
      @(negedge clk);
      rst = r;
      btn = b;
      for (int k = 0; k < 2; k++) model_cycle(k, r, b);
      exp_q0.push_back(model_out(0));
      exp_q1.push_back(model_out(1));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0);
   endtask

   task automatic press();
      drive(1'b0, 1'b1);
      drive(1'b0, 1'b0);
   endtask

   // Monitor / scoreboard: compare DUT outputs just after each rising edge.
   initial begin
      logic [7:0] got;
      logic [7:0] exp_v;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (exp_q0.size() > 0) begin
            exp_v = exp_q0.pop_front();
            got   = {led0, mode0, dir0, step0};
            checks++;
            if (got !== exp_v) begin
               fails++;
               $display("FAIL chaser4 cycle %0d got led/mode/dir/step %b required %b",
                        cyc, got, exp_v);
            end
         end
         if (exp_q1.size() > 0) begin
            exp_v = exp_q1.pop_front();
            got   = {2'b00, led1, mode1, dir1, step1};
            checks++;
            if (got !== exp_v) begin
               fails++;
               $display("FAIL chaser2 cycle %0d got led/mode/dir/step %b required %b",
                        cyc, got, exp_v);
            end
         end
      end
   end

   // Stimulus sequence
   initial begin
      bit b;
      bit r;
      int guard;

      // reset, then plain UP sweep with wrap
      drive(1'b1, 1'b0);
      drive(1'b1, 1'b0);
      idle(14);

      // UP -> DOWN, sweep with wrap
      press();
      idle(15);

      // DOWN -> BOUNCE, several reflections
      press();
      idle(25);

      // button held high: single mode change
      for (int i = 0; i < 20; i++) drive(1'b0, 1'b1);
      idle(6);

      // button held across reset, released later: no mode change
      drive(1'b1, 1'b1);
      drive(1'b1, 1'b1);
      for (int i = 0; i < 5; i++) drive(1'b0, 1'b1);
      idle(6);

      // reach BOUNCE at pos 2, then reset mid-operation
      guard = 0;
      while (m_mode[0] != 2 && guard < 4) begin press(); guard++; end
      guard = 0;
      while (m_pos[0] != 2 && guard < 40) begin drive(1'b0, 1'b0); guard++; end
      drive(1'b1, 1'b0);
      idle(8);

      // button edge coinciding with a step edge
      for (int rep = 0; rep < 3; rep++) begin
         guard = 0;
         while (m_cnt[0] != tdiv[0] - 1 && guard < 10) begin
            drive(1'b0, 1'b0); guard++;
         end
         drive(1'b0, 1'b1);
         idle(7);
      end

      // randomized button activity with occasional reset
      b = 1'b0;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 5) == 0) b = ~b;
         r = ($urandom_range(0, 99) == 0);
         drive(r, b);
      end
      idle(4);

      @(posedge clk);
      #2;
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
